color_matrix_apply: RTL and testbench

Streaming consumer of the compensation matrix produced by `bradford_chromatic_adapt`. It applies the 3x3 Q16.16 matrix to a pixel stream, one RGB pixel per cycle, using a 3-stage pipeline with valid/ready backpressure. New matrices take effect only at frame boundaries. It sits between the video input path and the display output.

---
 rtl/color_adapt_pkg.sv | 17 +
 rtl/cma_dot3.sv | 86 ++++++++
 rtl/color_matrix_apply.sv | 99 +++++++++
 tb/tb_color_matrix_apply.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_adapt_pkg.sv
// Shared Q16.16 colour-adaptation types and constants.
// Used by bradford_chromatic_adapt (producer) and color_matrix_apply (consumer).
package color_adapt_pkg;

    localparam int              Q_FRAC = 16;
    localparam logic [31:0]     Q_ONE  = 32'h0001_0000;

    typedef logic signed [31:0] q16_16_t;

    // Row-major 3x3; element i at [32*i +: 32], so element 8 sits in the MSBs.
    localparam logic [9*32-1:0] IDENTITY_FLAT = {
        Q_ONE, 32'h0, 32'h0,
        32'h0, Q_ONE, 32'h0,
        32'h0, 32'h0, Q_ONE
    };

endpackage

// File: rtl/cma_dot3.sv
// One output channel: 3 signed products (S1), rounded sum (S2), clamped result (S3).
// Latency 3 cycles; every stage advances only when en is high, otherwise holds.
// With COLOR_MATRIX_BYPASS_EN the raw channel rides alongside and replaces S3 when bypass=1.
module cma_dot3 #(
    parameter int CH_W   = 8,
    parameter int COEF_W = 32,
    parameter int FRAC   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [COEF_W-1:0] coef0,
    input  logic signed [COEF_W-1:0] coef1,
    input  logic signed [COEF_W-1:0] coef2,
    input  logic        [CH_W-1:0]   r,
    input  logic        [CH_W-1:0]   g,
    input  logic        [CH_W-1:0]   b,
`ifdef COLOR_MATRIX_BYPASS_EN
    input  logic                     bypass,
    input  logic        [CH_W-1:0]   raw,
`endif
    output logic        [CH_W-1:0]   ch_out
);

    localparam int PROD_W = COEF_W + CH_W + 1;
    localparam int SUM_W  = PROD_W + 2;
    localparam logic signed [SUM_W-1:0] HALF = SUM_W'(64'd1 << (FRAC - 1));
    localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((64'd1 << CH_W) - 1);

    logic signed [PROD_W-1:0] p0_d, p1_d, p2_d;
    logic signed [PROD_W-1:0] p0_q, p1_q, p2_q;
    logic signed [SUM_W-1:0]  sum_d, rnd_d, rnd_q;
    logic        [CH_W-1:0]   clamp_d;

    // Channels are unsigned, so a zero MSB makes them safe signed operands.
    assign p0_d = PROD_W'(coef0) * PROD_W'($signed({1'b0, r}));
    assign p1_d = PROD_W'(coef1) * PROD_W'($signed({1'b0, g}));
    assign p2_d = PROD_W'(coef2) * PROD_W'($signed({1'b0, b}));

    assign sum_d = SUM_W'(p0_q) + SUM_W'(p1_q) + SUM_W'(p2_q) + HALF;
    assign rnd_d = sum_d >>> FRAC;

    always_comb begin
        clamp_d = rnd_q[CH_W-1:0];
        if (rnd_q < 0)
            clamp_d = '0;
        else if (rnd_q > MAXV)
            clamp_d = '1;
    end

`ifdef COLOR_MATRIX_BYPASS_EN
    logic            byp_q1, byp_q2;
    logic [CH_W-1:0] raw_q1, raw_q2;

    always_ff @(posedge clk) begin
        if (en) begin
            byp_q1 <= bypass;
            raw_q1 <= raw;
            byp_q2 <= byp_q1;
            raw_q2 <= raw_q1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (en) begin
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            p2_q  <= p2_d;
            rnd_q <= rnd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_out <= '0;
        end else if (en) begin
`ifdef COLOR_MATRIX_BYPASS_EN
            ch_out <= byp_q2 ? raw_q2 : clamp_d;
`else
            ch_out <= clamp_d;
`endif
        end
    end

endmodule

// File: rtl/color_matrix_apply.sv
// Applies a 3x3 Q16.16 matrix to an RGB stream; new matrices swap in on the next SOF.
// Latency 3 cycles, 1 pixel/cycle; whole pipeline freezes while output is valid and not ready.
// COLOR_MATRIX_BYPASS_EN adds a per-pixel bypass input that passes pixels through unchanged.
module color_matrix_apply
    import color_adapt_pkg::*;
#(
    parameter int CH_W   = 8,
    parameter int COEF_W = 32,
    parameter int FRAC   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9*COEF_W-1:0]   comp_matrix_flat,
    input  logic                  matrix_valid,
    input  logic [3*CH_W-1:0]     pix_in,
    input  logic                  pix_in_sof,
    input  logic                  pix_in_valid,
    output logic                  pix_in_ready,
`ifdef COLOR_MATRIX_BYPASS_EN
    input  logic                  bypass,
`endif
    output logic [3*CH_W-1:0]     pix_out,
    output logic                  pix_out_sof,
    output logic                  pix_out_valid,
    input  logic                  pix_out_ready,
    output logic                  matrix_pending
);

    logic [9*COEF_W-1:0] active, pending, use_mat;
    logic                en, accept, swap;
    logic                vld_q1, vld_q2, sof_q1, sof_q2;

    assign en           = !pix_out_valid || pix_out_ready;
    assign pix_in_ready = en;
    assign accept       = pix_in_valid && en;
    assign swap         = accept && pix_in_sof && matrix_pending;
    // The SOF pixel that triggers a swap already sees the incoming matrix.
    assign use_mat      = swap ? pending : active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active         <= (9*COEF_W)'(IDENTITY_FLAT);
            pending        <= '0;
            matrix_pending <= 1'b0;
        end else begin
            if (swap)
                active <= pending;
            // A strobe coinciding with the swap re-arms pending for the next frame.
            if (matrix_valid) begin
                pending        <= comp_matrix_flat;
                matrix_pending <= 1'b1;
            end else if (swap) begin
                matrix_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q1        <= 1'b0;
            vld_q2        <= 1'b0;
            pix_out_valid <= 1'b0;
            sof_q1        <= 1'b0;
            sof_q2        <= 1'b0;
            pix_out_sof   <= 1'b0;
        end else if (en) begin
            vld_q1        <= accept;
            vld_q2        <= vld_q1;
            pix_out_valid <= vld_q2;
            sof_q1        <= accept && pix_in_sof;
            sof_q2        <= sof_q1;
            pix_out_sof   <= sof_q2;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_ch
        cma_dot3 #(
            .CH_W   (CH_W),
            .COEF_W (COEF_W),
            .FRAC   (FRAC)
        ) u_dot3 (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .coef0  ($signed(use_mat[COEF_W*(3*k)   +: COEF_W])),
            .coef1  ($signed(use_mat[COEF_W*(3*k+1) +: COEF_W])),
            .coef2  ($signed(use_mat[COEF_W*(3*k+2) +: COEF_W])),
            .r      (pix_in[2*CH_W +: CH_W]),
            .g      (pix_in[CH_W   +: CH_W]),
            .b      (pix_in[0      +: CH_W]),
`ifdef COLOR_MATRIX_BYPASS_EN
            .bypass (bypass),
            .raw    (pix_in[CH_W*(2-k) +: CH_W]),
`endif
            .ch_out (pix_out[CH_W*(2-k) +: CH_W])
        );
    end

endmodule

// File: tb/tb_color_matrix_apply.sv
// Scoreboard bench for color_matrix_apply: expected pixels queued at accept, compared at output.
module tb_color_matrix_apply;
    import color_adapt_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [287:0]  comp_matrix_flat;
    logic          matrix_valid;
    logic [23:0]   pix_in;
    logic          pix_in_sof;
    logic          pix_in_valid;
    logic          pix_in_ready;
    logic [23:0]   pix_out;
    logic          pix_out_sof;
    logic          pix_out_valid;
    logic          pix_out_ready;
    logic          matrix_pending;
`ifdef COLOR_MATRIX_BYPASS_EN
    logic          bypass = 1'b0;
`endif

    color_matrix_apply dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .comp_matrix_flat (comp_matrix_flat),
        .matrix_valid     (matrix_valid),
        .pix_in           (pix_in),
        .pix_in_sof       (pix_in_sof),
        .pix_in_valid     (pix_in_valid),
        .pix_in_ready     (pix_in_ready),
`ifdef COLOR_MATRIX_BYPASS_EN
        .bypass           (bypass),
`endif
        .pix_out          (pix_out),
        .pix_out_sof      (pix_out_sof),
        .pix_out_valid    (pix_out_valid),
        .pix_out_ready    (pix_out_ready),
        .matrix_pending   (matrix_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] pix;
        logic        sof;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rx_cnt = 0;
    int          stall_n = 0;
    bit          prev_stall = 0;
    logic [23:0] prev_pix;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [287:0] diag(input logic [31:0] d);
        return {d, 32'h0, 32'h0, 32'h0, d, 32'h0, 32'h0, 32'h0, d};
    endfunction

    // Output monitor: scoreboard compare plus hold-while-stalled check.
    always @(negedge clk) begin
        exp_t e;
        if (prev_stall) begin
            check("stall_hold_pix", pix_out, prev_pix);
            check("stall_hold_vld", pix_out_valid, 1);
        end
        if (pix_out_valid === 1'b1 && pix_out_ready) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pix_out", pix_out, e.pix);
                check("pix_out_sof", pix_out_sof, e.sof);
                if (e.lat) check("latency", cyc - e.cyc, 3);
                rx_cnt++;
            end
        end
        prev_stall = (pix_out_valid === 1'b1) && !pix_out_ready;
        if (prev_stall) stall_n++;
        prev_pix = pix_out;
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [23:0] p, input logic s, input logic [23:0] e, input bit lat = 0);
        int n = 0;
        exp_t x;
        pix_in = p; pix_in_sof = s; pix_in_valid = 1'b1;
        @(negedge clk);
        while (!pix_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pix_in_ready) begin
            check("in_timeout", pix_in_ready, 1);
        end else begin
            x.pix = e; x.sof = s; x.cyc = cyc; x.lat = lat;
            sb.push_back(x);
        end
        @(posedge clk); #1;
        pix_in_valid = 1'b0; pix_in_sof = 1'b0;
    endtask

    task automatic strobe(input logic [287:0] m);
        comp_matrix_flat = m; matrix_valid = 1'b1;
        @(posedge clk); #1;
        matrix_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [287:0] m;
        int           rx0;

        rst_n = 1'b0; matrix_valid = 1'b0; comp_matrix_flat = '0;
        pix_in = '0; pix_in_sof = 1'b0; pix_in_valid = 1'b0; pix_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", pix_out_valid, 0);
        check("rst_sof", pix_out_sof, 0);
        check("rst_pix", pix_out, 0);
        check("rst_pending", matrix_pending, 0);
        check("rst_ready", pix_in_ready, 1);
        @(posedge clk); #1;

        // Identity after reset, with latency measured.
        send(24'h804020, 1, 24'h804020, 1);
        drain();

        // Diagonal 2.0: R clamps high.
        strobe(diag(32'h0002_0000));
        check("pend_set", matrix_pending, 1);
        send(24'h804020, 1, 24'hFF8040);
        check("pend_clr", matrix_pending, 0);
        drain();

        // Negative clamp on R.
        m = IDENTITY_FLAT;
        m[31:0] = 32'h0; m[63:32] = 32'hFFFF_0000; m[95:64] = 32'h0;
        strobe(m);
        send(24'h10F010, 1, 24'h00F010);
        drain();

        // Half-up rounding on R: 0.5 -> 1, 1.5 -> 2.
        m = IDENTITY_FLAT;
        m[31:0] = 32'h0000_8000; m[63:32] = 32'h0; m[95:64] = 32'h0;
        strobe(m);
        send(24'h010203, 1, 24'h010203);
        send(24'h030000, 0, 24'h020000);
        drain();

        // Mid-frame strobes leave active alone; the last strobe wins at SOF.
        strobe(IDENTITY_FLAT);
        send(24'h112233, 1, 24'h112233);
        send(24'h102030, 0, 24'h102030);
        strobe(diag(32'h0002_0000));
        send(24'h102030, 0, 24'h102030);
        send(24'h405060, 0, 24'h405060);
        strobe(diag(32'h0000_8000));
        check("pend_mid", matrix_pending, 1);
        send(24'h102030, 1, 24'h081018);
        drain();

        // 20-pixel stream with a 5-cycle downstream stall.
        strobe(IDENTITY_FLAT);
        rx0 = rx_cnt; stall_n = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send(24'(i * 3 + 5), (i == 0), 24'(i * 3 + 5));
            end
            begin
                repeat (8) @(posedge clk);
                #1 pix_out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 pix_out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", rx_cnt - rx0, 20);
        check("stall_seen", stall_n > 0, 1);

        // Reset with pixels in flight and a matrix pending.
        strobe(diag(32'h0002_0000));
        send(24'h010203, 0, 24'h010203);
        send(24'h040506, 0, 24'h040506);
        send(24'h070809, 0, 24'h070809);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst2_valid", pix_out_valid, 0);
        check("rst2_pending", matrix_pending, 0);
        check("rst2_ready", pix_in_ready, 1);
        @(posedge clk); #1;
        send(24'h804020, 1, 24'h804020);
        send(24'h808080, 0, 24'h808080);
        drain();

        // Strobe coinciding with an SOF and nothing pending: SOF keeps active.
        fork
            strobe(diag(32'h0002_0000));
            send(24'h102030, 1, 24'h102030);
        join
        check("coinc_pend", matrix_pending, 1);
        send(24'h102030, 1, 24'h204060);
        check("coinc_clr", matrix_pending, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
